vc_test_nport_rand_delay_mem: RTL
=================================

// Module: vc_test_nport_rand_delay_mem
// PURPOSE
//  Test-harness memory with a parametrised number of independent req/resp ports.
//  Each port has its own response slot and an LFSR-driven random response delay.
//  One shared byte-addressed array is backed by vc mem req/resp messages.
//  Sits beside multi-port DUTs (cores, caches, accelerators) in simulation test harnesses.
// PARAMETERS
//  p_num_ports  4     number of req/resp port pairs (1..16)
//  p_mem_sz     1024  physical memory size in bytes (power of two)
//  p_addr_sz    8     request address width, bits
//  p_data_sz    32    data width, bits (multiple of 8, power of two)
//  p_max_delay  0     max extra response delay, cycles (0 = fixed minimum latency)
//  p_seed       16'hACE1  base LFSR seed; port i seeded p_seed^i, forced to 1 if zero
//  derived: c_len_sz=clog2(p_data_sz/8); c_req_sz=1+p_addr_sz+c_len_sz+p_data_sz; c_resp_sz=1+c_len_sz+p_data_sz
// PORTS
//  clk          in   1                   clock; all state updates on posedge
//  reset        in   1                   asynchronous, active-low reset
//  memreq_val   in   p_num_ports         per-port request valid
//  memreq_rdy   out  p_num_ports         per-port request ready
//  memreq_msg   in   p_num_ports*c_req   port i at [i*c_req_sz +: c_req_sz]; {type,addr,len,data}
//  memresp_val  out  p_num_ports         per-port response valid
//  memresp_rdy  in   p_num_ports         per-port response ready
//  memresp_msg  out  p_num_ports*c_resp  port i at [i*c_resp_sz +: c_resp_sz]; {type,len,data}
// BEHAVIOUR
//  Reset (reset==0, async): all slots empty; memreq_rdy=all 1s; memresp_val=0; memresp_msg=0.
//   Delay counters cleared; LFSRs reloaded with seeds. Memory array NOT cleared (harness preloads).
//   Reset mid-operation drops in-flight responses silently.
//  Per-port FSM, two states:
//   EMPTY -> FULL on memreq_val&memreq_rdy.
//   FULL  -> EMPTY on memresp_val&memresp_rdy.
//  memreq_rdy[i]=(state==EMPTY); no same-cycle refill, so peak throughput is 1 transaction per 2 cycles per port.
//  On accept: perform access immediately; latch resp msg; delay cnt <= lfsr % (p_max_delay+1); advance LFSR one step.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, advanced only on accept (delay sequence repeatable per port).
//  In FULL: cnt decrements to 0 and holds; memresp_val[i]=FULL && cnt==0.
//  Latency accept->resp_val = 1+delay cycles (delay 0: valid cycle after accept).
//  memresp_msg is stable while val=1 and rdy=0; val never drops without a handshake.
//  type 0=read, 1=write; len 0 means full word (p_data_sz/8 bytes), else len bytes.
//  Access is byte-granular, little-endian, at bytes addr..addr+n-1, each byte address taken modulo p_mem_sz.
//  Read: resp data = bytes read, zero-extended above n bytes. Write: bytes stored; resp data=0.
//  Resp type and len echo the request.
//  Same-cycle accesses across ports:
//   - Reads return pre-cycle contents (read-before-write).
//   - Writes apply in ascending port order, so the highest-index port wins on overlapping bytes.
//  Ports fully independent otherwise: a stalled memresp_rdy on one port never blocks another.
//  Unknown type (never generated): treated as read.
// TESTING
//  T1 p_max_delay=0, port0: write 0xDEADBEEF @0x10 len0, then read @0x10.
//   -> resp1 type1 data0; resp2 type0 data 0xDEADBEEF; each valid 1 cycle after accept.
//  T2 len=1 write 0xAB @0x13 over word 0x11223344 @0x10; read word.
//   -> 0xAB223344. Read len2 @0x12 -> 0x0000AB22.
//  T3 ports 1 and 3 write same cycle @0x20 (0x1111 vs 0x3333); port2 reads @0x20 same cycle.
//   -> port2 gets old value; next read -> 0x3333.
//  T4 p_max_delay=7, 200 random txns on all ports, hold memresp_rdy[2]=0 for 50 cycles.
//   -> other ports progress; port2 val/msg stable; all data match golden model; every delay in 0..7.
//  T5 Assert reset low mid-transaction with port0 FULL.
//   -> next cycle val=0, rdy=1; memory retains prior writes; delay sequence after reset repeats first run.
//  T6 Address 0x3FE len0 with p_mem_sz=1024, p_addr_sz=12.
//   -> bytes 0x3FE,0x3FF,0x000,0x001 accessed (wrap-around).

Source files
------------

// File: rtl/vc_test_nport_rand_delay_mem.sv
// Multi-port test-harness memory: one shared byte array, per-port response slot
// with an LFSR-driven random response delay so the attached DUT sees varied latency.
module vc_test_nport_rand_delay_mem #(
  parameter int          p_num_ports = 4,
  parameter int          p_mem_sz    = 1024,
  parameter int          p_addr_sz   = 8,
  parameter int          p_data_sz   = 32,
  parameter int          p_max_delay = 0,
  parameter logic [15:0] p_seed      = 16'hACE1,
  localparam int c_len_sz  = $clog2(p_data_sz/8),
  localparam int c_req_sz  = 1 + p_addr_sz + c_len_sz + p_data_sz,
  localparam int c_resp_sz = 1 + c_len_sz + p_data_sz
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_ports-1:0]           memreq_val,
  output logic [p_num_ports-1:0]           memreq_rdy,
  input  logic [p_num_ports*c_req_sz-1:0]  memreq_msg,
  output logic [p_num_ports-1:0]           memresp_val,
  input  logic [p_num_ports-1:0]           memresp_rdy,
  output logic [p_num_ports*c_resp_sz-1:0] memresp_msg
);

  localparam int c_bytes  = p_data_sz / 8;
  localparam int c_mem_aw = $clog2(p_mem_sz);
  localparam int c_cnt_sz = $clog2(p_max_delay + 2);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t               r_state [p_num_ports];
  logic [c_cnt_sz-1:0]  r_cnt   [p_num_ports];
  logic [15:0]          r_lfsr  [p_num_ports];
  logic [c_resp_sz-1:0] r_resp  [p_num_ports];
  logic [7:0]           r_mem   [p_mem_sz];

  logic                 w_type  [p_num_ports];
  logic [p_addr_sz-1:0] w_addr  [p_num_ports];
  logic [c_len_sz-1:0]  w_len   [p_num_ports];
  logic [p_data_sz-1:0] w_wdata [p_num_ports];
  logic [p_data_sz-1:0] w_rdata [p_num_ports];
  logic [c_resp_sz-1:0] w_resp  [p_num_ports];
  logic [c_mem_aw-1:0]  w_baddr [p_num_ports][c_bytes];
  logic [c_bytes-1:0]   w_bmask [p_num_ports];
  logic [p_num_ports-1:0] w_accept;
  logic [p_num_ports-1:0] w_deliver;

  function automatic logic [15:0] f_seed(input int idx);
    logic [15:0] s;
    s = p_seed ^ 16'(idx);
    return (s == 16'd0) ? 16'd1 : s;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
  function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [c_cnt_sz-1:0] f_delay(input logic [15:0] s);
    return c_cnt_sz'(s % 16'(p_max_delay + 1));
  endfunction

  // Request decode and read path; reads see the array as it stood before this edge.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, otherwise the unassigned paths would infer latches.
  always_comb begin
    for (int i = 0; i < p_num_ports; i++) begin
      w_type[i]  = memreq_msg[i*c_req_sz + c_req_sz - 1];
      w_addr[i]  = memreq_msg[i*c_req_sz + p_data_sz + c_len_sz +: p_addr_sz];
      w_len[i]   = memreq_msg[i*c_req_sz + p_data_sz +: c_len_sz];
      w_wdata[i] = memreq_msg[i*c_req_sz +: p_data_sz];
      w_rdata[i] = '0;
      for (int b = 0; b < c_bytes; b++) begin
        w_baddr[i][b] = c_mem_aw'(32'(w_addr[i]) + 32'(b));
        w_bmask[i][b] = (w_len[i] == '0) || (b < int'(w_len[i]));
        if (w_bmask[i][b])
          w_rdata[i][b*8 +: 8] = r_mem[w_baddr[i][b]];
      end
      w_resp[i] = {w_type[i], w_len[i],
                   (w_type[i] ? {p_data_sz{1'b0}} : w_rdata[i])};
    end
  end

  always_comb begin
    memresp_msg = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      memreq_rdy[i]  = (r_state[i] == ST_EMPTY);
      memresp_val[i] = (r_state[i] == ST_FULL) && (r_cnt[i] == '0);
      memresp_msg[i*c_resp_sz +: c_resp_sz] = r_resp[i];
    end
    w_accept  = memreq_val & memreq_rdy;
    w_deliver = memresp_val & memresp_rdy;
  end

  // NOTE: the byte array is deliberately left out of reset so the harness
  // can preload it and contents survive a mid-test reset. Later ports are
  // visited later in the loop, so their bytes win on overlap.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_ports; i++) begin
      if (w_accept[i] && w_type[i]) begin
        for (int b = 0; b < c_bytes; b++) begin
          if (w_bmask[i][b])
            r_mem[w_baddr[i][b]] <= w_wdata[i][b*8 +: 8];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // port's next state is computed from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_num_ports; i++) begin
        r_state[i] <= ST_EMPTY;
        r_cnt[i]   <= '0;
        r_lfsr[i]  <= f_seed(i);
        r_resp[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < p_num_ports; i++) begin
        case (r_state[i])
          ST_EMPTY: begin
            if (memreq_val[i]) begin
              r_state[i] <= ST_FULL;
              r_resp[i]  <= w_resp[i];
              r_cnt[i]   <= f_delay(r_lfsr[i]);
              r_lfsr[i]  <= f_lfsr_next(r_lfsr[i]);
            end
          end
          default: begin
            if (r_cnt[i] != '0)
              r_cnt[i] <= r_cnt[i] - 1'b1;
            if (w_deliver[i])
              r_state[i] <= ST_EMPTY;
          end
        endcase
      end
    end
  end

endmodule
